// File: rtl/pwr_seq_pkg.sv
// Shared encodings and default timing for the S5->S0 power-rail sequencer.
// Timing defaults assume the 7.8125 MHz (128 ns) clk0 from the PLL.
package pwr_seq_pkg;

  typedef enum logic [3:0] {
    ST_OFF       = 4'd0,
    ST_WAIT_VDDQ = 4'd1,
    ST_WAIT_VTT  = 4'd2,
    ST_WAIT_CORE = 4'd3,
    ST_DLY_RST   = 4'd4,
    ST_DLY_MEM   = 4'd5,
    ST_ON        = 4'd6,
    ST_DOWN      = 4'd7,
    ST_FAULT     = 4'd8
  } pwr_state_e;

  localparam logic [1:0] FC_NONE = 2'd0;
  localparam logic [1:0] FC_VDDQ = 2'd1;
  localparam logic [1:0] FC_VTT  = 2'd2;
  localparam logic [1:0] FC_CORE = 2'd3;

  localparam int unsigned T_10MS_DEF     = 78125;
  localparam int unsigned T_20MS_DEF     = 156250;
  localparam int unsigned T_PGTO_DEF     = 781250;
  localparam int unsigned T_OFF_STEP_DEF = 7812;

  // Rails are indexed 0=VDDQ, 1=VTT, 2=CORE; the lowest dropped rail reports.
  function automatic logic [1:0] dropCode(input logic [2:0] dropped);
    if (dropped[0])      return FC_VDDQ;
    else if (dropped[1]) return FC_VTT;
    else if (dropped[2]) return FC_CORE;
    else                 return FC_NONE;
  endfunction

  function automatic logic [1:0] railCode(input logic [1:0] rail);
    return rail + 2'd1;
  endfunction

endpackage

// File: rtl/pwr_seq_ctrl_btn_debounce.sv
// Button synchronizer and debouncer: one press_o pulse per continuous low period
// of T_DEB cycles; re-arms only once the button is seen released.
module btn_debounce #(
  parameter int unsigned T_DEB = 156250,
  parameter int          CNT_W = 20
) (
  input  logic clk0,
  input  logic rstn,
  input  logic btn_n_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(T_DEB - 1);

  logic             meta_q;
  logic             sync_q;
  logic             armed_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q;

  // Starts disarmed so a button held through reset never produces a press.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_n_i;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      if (sync_q) begin
        armed_q <= 1'b1;
        cnt_q   <= '0;
      end else if (armed_q) begin
        if (cnt_q == DEB_LAST) begin
          press_q <= 1'b1;
          armed_q <= 1'b0;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pwr_seq_ctrl.sv
// Closed-loop S5->S0 rail sequencer: PG-gated power-up, PG timeouts,
// ordered shutdown and a sticky fault state, all on one shared counter.
module pwr_seq_ctrl
  import pwr_seq_pkg::*;
#(
  parameter int unsigned T_10MS     = T_10MS_DEF,
  parameter int unsigned T_20MS     = T_20MS_DEF,
  parameter int unsigned T_PGTO     = T_PGTO_DEF,
  parameter int unsigned T_OFF_STEP = T_OFF_STEP_DEF,
  parameter int          CNT_W      = 20
) (
  input  logic       clk0,
  input  logic       rstn,
  input  logic       pwrbtn_n,
  input  logic       vddq_vpp_pg,
  input  logic       vtt_pg,
  input  logic       core_pg,
  output logic       vddq_vpp_en,
  output logic       vtt_en,
  output logic       vdd_core_en,
  output logic       p1v8_en,
  output logic       pcie_rst_n,
  output logic       mem_rst_n,
  output logic       sys_on,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(T_10MS - 1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(T_20MS - 1);
  localparam logic [CNT_W-1:0] PGTO_LAST   = CNT_W'(T_PGTO - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(T_OFF_STEP - 1);

  pwr_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       pgMeta_q, pgSync_q, conf_q;
  logic [3:0]       en_q;
  logic             pcieRst_q, memRst_q, sysOn_q, fault_q;
  logic [1:0]       faultCode_q;

  logic       press;
  logic [1:0] waitRail;
  pwr_state_e waitNext;
  logic       inWait, checkDrop, pgTimeout, faultNow;
  logic [2:0] dropped;
  logic [1:0] faultCodeNow;

  btn_debounce #(
    .T_DEB (T_20MS),
    .CNT_W (CNT_W)
  ) uBtn (
    .clk0    (clk0),
    .rstn    (rstn),
    .btn_n_i (pwrbtn_n),
    .press_o (press)
  );

  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      pgMeta_q <= '0;
      pgSync_q <= '0;
    end else begin
      pgMeta_q <= {core_pg, vtt_pg, vddq_vpp_pg};
      pgSync_q <= pgMeta_q;
    end
  end

  // The three WAIT states share one body, parameterised by the rail they watch.
  always_comb begin
    waitRail  = 2'd0;
    waitNext  = ST_WAIT_VTT;
    inWait    = 1'b0;
    checkDrop = 1'b0;
    case (state_q)
      ST_WAIT_VDDQ: begin
        inWait    = 1'b1;
        checkDrop = 1'b1;
      end
      ST_WAIT_VTT: begin
        waitRail  = 2'd1;
        waitNext  = ST_WAIT_CORE;
        inWait    = 1'b1;
        checkDrop = 1'b1;
      end
      ST_WAIT_CORE: begin
        waitRail  = 2'd2;
        waitNext  = ST_DLY_RST;
        inWait    = 1'b1;
        checkDrop = 1'b1;
      end
      ST_DLY_RST, ST_DLY_MEM, ST_ON: checkDrop = 1'b1;
      default: ;
    endcase
  end

  assign dropped      = conf_q & ~pgSync_q;
  assign pgTimeout    = inWait && !conf_q[waitRail] && !pgSync_q[waitRail] && (cnt_q == PGTO_LAST);
  assign faultNow     = (checkDrop && (|dropped)) || pgTimeout;
  assign faultCodeNow = (|dropped) ? dropCode(dropped) : railCode(waitRail);

  // Fault entry overrides every state body, which also gives it priority over a press in ON.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      conf_q      <= '0;
      en_q        <= '0;
      pcieRst_q   <= 1'b0;
      memRst_q    <= 1'b0;
      sysOn_q     <= 1'b0;
      fault_q     <= 1'b0;
      faultCode_q <= FC_NONE;
    end else if (faultNow) begin
      state_q     <= ST_FAULT;
      cnt_q       <= '0;
      conf_q      <= '0;
      en_q        <= '0;
      pcieRst_q   <= 1'b0;
      memRst_q    <= 1'b0;
      sysOn_q     <= 1'b0;
      fault_q     <= 1'b1;
      faultCode_q <= faultCodeNow;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        ST_OFF: begin
          cnt_q  <= '0;
          conf_q <= '0;
          if (press) begin
            en_q[0] <= 1'b1;
            state_q <= ST_WAIT_VDDQ;
          end
        end
        ST_WAIT_VDDQ, ST_WAIT_VTT, ST_WAIT_CORE: begin
          if (conf_q[waitRail]) begin
            if (cnt_q == SETTLE_LAST) begin
              en_q[waitRail + 2'd1] <= 1'b1;
              state_q               <= waitNext;
              cnt_q                 <= '0;
            end
          end else if (pgSync_q[waitRail]) begin
            conf_q[waitRail] <= 1'b1;
            cnt_q            <= CNT_W'(1);
          end
        end
        ST_DLY_RST: begin
          if (cnt_q == RST_LAST) begin
            pcieRst_q <= 1'b1;
            state_q   <= ST_DLY_MEM;
            cnt_q     <= '0;
          end
        end
        ST_DLY_MEM: begin
          if (cnt_q == RST_LAST) begin
            memRst_q <= 1'b1;
            sysOn_q  <= 1'b1;
            state_q  <= ST_ON;
            cnt_q    <= '0;
          end
        end
        ST_ON: begin
          cnt_q <= '0;
          if (press) begin
            pcieRst_q <= 1'b0;
            memRst_q  <= 1'b0;
            sysOn_q   <= 1'b0;
            state_q   <= ST_DOWN;
          end
        end
        ST_DOWN: begin
          // Enables always form a contiguous low mask, so a right shift drops the highest rail.
          if (en_q == 4'd0) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
          end else if (cnt_q == STEP_LAST) begin
            en_q  <= en_q >> 1;
            cnt_q <= '0;
          end
        end
        ST_FAULT: begin
          cnt_q <= '0;
          if (press) begin
            fault_q     <= 1'b0;
            faultCode_q <= FC_NONE;
            state_q     <= ST_OFF;
          end
        end
        default: begin
          state_q <= ST_OFF;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign vddq_vpp_en = en_q[0];
  assign vtt_en      = en_q[1];
  assign vdd_core_en = en_q[2];
  assign p1v8_en     = en_q[3];
  assign pcie_rst_n  = pcieRst_q;
  assign mem_rst_n   = memRst_q;
  assign sys_on      = sysOn_q;
  assign fault       = fault_q;
  assign fault_code  = faultCode_q;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl with short timing parameters; expected
// output vectors are hand-computed cycle counts from each stimulus edge.
module tb_pwr_seq_ctrl;

  // Output vector layout: {vddq, vtt, core, p1v8}_{pcie, mem, sys_on}_{fault}_{code}
  localparam logic [9:0] O_OFF = 10'b0000_000_0_00;
  localparam logic [9:0] O_E1  = 10'b1000_000_0_00;
  localparam logic [9:0] O_E2  = 10'b1100_000_0_00;
  localparam logic [9:0] O_E3  = 10'b1110_000_0_00;
  localparam logic [9:0] O_E4  = 10'b1111_000_0_00;
  localparam logic [9:0] O_E4P = 10'b1111_100_0_00;
  localparam logic [9:0] O_ON  = 10'b1111_111_0_00;
  localparam logic [9:0] O_F2  = 10'b0000_000_1_10;
  localparam logic [9:0] O_F3  = 10'b0000_000_1_11;

  typedef struct packed {
    logic       btnN;
    logic [2:0] pg;
    logic [7:0] waitCyc;
    logic [9:0] expOut;
  } vec_t;

  logic       clk0 = 1'b0;
  logic       rstn;
  logic       pwrbtn_n;
  logic       vddq_vpp_pg, vtt_pg, core_pg;
  logic       vddq_vpp_en, vtt_en, vdd_core_en, p1v8_en;
  logic       pcie_rst_n, mem_rst_n, sys_on, fault;
  logic [1:0] fault_code;
  logic [9:0] outVec;

  int   testsRun    = 0;
  int   testsFailed = 0;
  vec_t vecs [26];

  pwr_seq_ctrl #(
    .T_10MS     (10),
    .T_20MS     (20),
    .T_PGTO     (50),
    .T_OFF_STEP (5),
    .CNT_W      (20)
  ) dut (
    .clk0        (clk0),
    .rstn        (rstn),
    .pwrbtn_n    (pwrbtn_n),
    .vddq_vpp_pg (vddq_vpp_pg),
    .vtt_pg      (vtt_pg),
    .core_pg     (core_pg),
    .vddq_vpp_en (vddq_vpp_en),
    .vtt_en      (vtt_en),
    .vdd_core_en (vdd_core_en),
    .p1v8_en     (p1v8_en),
    .pcie_rst_n  (pcie_rst_n),
    .mem_rst_n   (mem_rst_n),
    .sys_on      (sys_on),
    .fault       (fault),
    .fault_code  (fault_code)
  );

  always #5 clk0 = ~clk0;

  assign outVec = {vddq_vpp_en, vtt_en, vdd_core_en, p1v8_en,
                   pcie_rst_n, mem_rst_n, sys_on, fault, fault_code};

  // Every drive and check happens 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk0);
    #1;
  endtask

  task automatic applyStimulus(input logic btnN, input logic [2:0] pg);
    pwrbtn_n    = btnN;
    vddq_vpp_pg = pg[0];
    vtt_pg      = pg[1];
    core_pg     = pg[2];
  endtask

  task automatic checkOutput(input string name, input logic [9:0] expOut);
    testsRun++;
    if (outVec !== expOut) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, outVec, expOut);
    end
  endtask

  task automatic pressButton(input int len);
    applyStimulus(1'b0, {core_pg, vtt_pg, vddq_vpp_pg});
    tick(len);
    applyStimulus(1'b1, {core_pg, vtt_pg, vddq_vpp_pg});
  endtask

  // From OFF with all PGs low: each PG rises 3 cycles after its enable; ends 5 cycles into DLY_RST.
  task automatic rampToDly();
    applyStimulus(1'b0, 3'b000);
    tick(26);
    applyStimulus(1'b1, 3'b001);
    tick(15);
    applyStimulus(1'b1, 3'b011);
    tick(15);
    applyStimulus(1'b1, 3'b111);
    tick(17);
    checkOutput("rampToDly", O_E4);
  endtask

  task automatic powerUp();
    rampToDly();
    tick(35);
    checkOutput("powerUp", O_ON);
  endtask

  initial begin
    // Normal power-up from OFF, then an ordered shutdown; waits are relative to the previous row.
    vecs[0]  = '{1'b0, 3'b000, 8'd22, O_OFF};
    vecs[1]  = '{1'b0, 3'b000, 8'd1,  O_E1};
    vecs[2]  = '{1'b0, 3'b000, 8'd3,  O_E1};
    vecs[3]  = '{1'b0, 3'b001, 8'd4,  O_E1};
    vecs[4]  = '{1'b1, 3'b001, 8'd7,  O_E1};
    vecs[5]  = '{1'b1, 3'b001, 8'd1,  O_E2};
    vecs[6]  = '{1'b1, 3'b001, 8'd3,  O_E2};
    vecs[7]  = '{1'b1, 3'b011, 8'd11, O_E2};
    vecs[8]  = '{1'b1, 3'b011, 8'd1,  O_E3};
    vecs[9]  = '{1'b1, 3'b011, 8'd3,  O_E3};
    vecs[10] = '{1'b1, 3'b111, 8'd11, O_E3};
    vecs[11] = '{1'b1, 3'b111, 8'd1,  O_E4};
    vecs[12] = '{1'b1, 3'b111, 8'd19, O_E4};
    vecs[13] = '{1'b1, 3'b111, 8'd1,  O_E4P};
    vecs[14] = '{1'b1, 3'b111, 8'd19, O_E4P};
    vecs[15] = '{1'b1, 3'b111, 8'd1,  O_ON};
    vecs[16] = '{1'b0, 3'b111, 8'd22, O_ON};
    vecs[17] = '{1'b0, 3'b111, 8'd1,  O_E4};
    vecs[18] = '{1'b1, 3'b111, 8'd4,  O_E4};
    vecs[19] = '{1'b1, 3'b111, 8'd1,  O_E3};
    vecs[20] = '{1'b1, 3'b111, 8'd4,  O_E3};
    vecs[21] = '{1'b1, 3'b111, 8'd1,  O_E2};
    vecs[22] = '{1'b1, 3'b111, 8'd5,  O_E1};
    vecs[23] = '{1'b1, 3'b111, 8'd4,  O_E1};
    vecs[24] = '{1'b1, 3'b111, 8'd1,  O_OFF};
    vecs[25] = '{1'b1, 3'b000, 8'd10, O_OFF};

    rstn = 1'b0;
    applyStimulus(1'b1, 3'b000);
    tick(3);
    checkOutput("resetState", O_OFF);
    rstn = 1'b1;
    tick(5);

    // Debounce boundaries in OFF.
    pressButton(15);
    tick(30);
    checkOutput("shortPress15", O_OFF);
    pressButton(19);
    tick(30);
    checkOutput("shortPress19", O_OFF);

    // Exactly 20 low cycles is a press; VTT PG never arrives.
    pressButton(20);
    tick(2);
    checkOutput("pressLatency22", O_OFF);
    tick(1);
    checkOutput("pressLatency23", O_E1);
    tick(3);
    applyStimulus(1'b1, 3'b001);
    tick(12);
    checkOutput("vttEnable", O_E2);
    tick(49);
    checkOutput("preTimeout", O_E2);
    tick(1);
    checkOutput("vttTimeout", O_F2);

    applyStimulus(1'b1, 3'b000);
    pressButton(15);
    tick(30);
    checkOutput("faultShortPress", O_F2);

    // A 100-cycle hold clears the fault and must not also start a new power-up.
    applyStimulus(1'b0, 3'b000);
    tick(22);
    checkOutput("faultHold22", O_F2);
    tick(1);
    checkOutput("faultClear", O_OFF);
    tick(77);
    applyStimulus(1'b1, 3'b000);
    tick(30);
    checkOutput("holdOneEvent", O_OFF);

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].btnN, vecs[i].pg);
      tick(int'(vecs[i].waitCyc));
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
    end

    // Brown-out on CORE landing in the same cycle as a press event.
    powerUp();
    applyStimulus(1'b0, 3'b111);
    tick(20);
    applyStimulus(1'b0, 3'b011);
    tick(2);
    checkOutput("brownOutPre", O_ON);
    tick(1);
    checkOutput("brownOut", O_F3);
    tick(5);
    applyStimulus(1'b1, 3'b011);
    tick(30);
    checkOutput("pressIgnored", O_F3);

    applyStimulus(1'b1, 3'b000);
    pressButton(25);
    tick(10);
    checkOutput("faultClear2", O_OFF);

    // VTT and CORE drop together: the lower code is reported.
    powerUp();
    applyStimulus(1'b1, 3'b001);
    tick(3);
    checkOutput("lowestCode", O_F2);
    applyStimulus(1'b1, 3'b000);
    pressButton(25);
    tick(10);
    checkOutput("faultClear3", O_OFF);

    // Asynchronous reset mid-sequence, then no enable without a new press.
    rampToDly();
    #3;
    rstn = 1'b0;
    #1;
    checkOutput("asyncReset", O_OFF);
    tick(2);
    rstn = 1'b1;
    tick(40);
    checkOutput("noEnableAfterReset", O_OFF);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
